clock_meter: RTL and testbench

- Measures the period and high time of a slow periodic 1-bit signal (a divided clock, tick, or external strobe) in `clk` cycles.
- It is the receiving end of a divided-clock output: it recovers the division period and duty from the waveform.
- Results are delivered through a valid/ready handshake to a consumer such as a debug register bank or self-check logic.
- A timeout detects a stopped input.

---
 rtl/clock_meter_pkg.sv | 33 +++
 rtl/clock_meter_edge_sync.sv | 35 +++
 rtl/clock_meter.sv | 169 ++++++++++++++++
 tb/tb_clock_meter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// clock_meter_pkg: shared types and helpers for the clock meter.
//   meter_state_t : measurement FSM states.
//   sat_limit     : all-ones value for a given counter width.
//   sat_add       : saturating add of two counts at a given width.
//   add_overflows : flags whether that add would exceed the width.
// Helpers work on MaxWidth-bit operands so any WIDTH up to MaxWidth can share them.
package clock_meter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} meter_state_t;

  localparam int unsigned MaxWidth = 64;

  function automatic logic [MaxWidth:0] sat_limit(input int unsigned width);
    return ({{MaxWidth{1'b0}}, 1'b1} << width) - {{MaxWidth{1'b0}}, 1'b1};
  endfunction

  function automatic logic add_overflows(input logic [MaxWidth-1:0] a,
                                         input logic [MaxWidth-1:0] b,
                                         input int unsigned         width);
    return ({1'b0, a} + {1'b0, b}) > sat_limit(width);
  endfunction

  function automatic logic [MaxWidth-1:0] sat_add(input logic [MaxWidth-1:0] a,
                                                  input logic [MaxWidth-1:0] b,
                                                  input int unsigned         width);
    logic [MaxWidth:0] sum;
    logic [MaxWidth:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = sat_limit(width);
    return (sum > lim) ? lim[MaxWidth-1:0] : sum[MaxWidth-1:0];
  endfunction

endpackage

// File: rtl/clock_meter_edge_sync.sv
// edge_sync: synchronizes an asynchronous level and flags its edges.
//   clk, reset : clock and synchronous active-high reset.
//   d          : asynchronous input level.
//   q          : synchronized level.
//   rise, fall : one-cycle pulses on a synchronized 0->1 / 1->0 change.
// Latency from d to an edge pulse being consumed is SYNC_STAGES+1 clocks.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/clock_meter.sv
// clock_meter: measures period and high time of a slow periodic signal in clk cycles.
//   clk, reset : clock and synchronous active-high reset.
//   sig_in     : measured signal, asynchronous to clk.
//   enable     : measurement enable; low returns to IDLE.
//   period     : high + low count of the last published measurement (saturating).
//   high_time  : high count of the last published measurement.
//   sat        : a count saturated during the published measurement.
//   valid      : result available; held with stable data until ready.
//   ready      : consumer accepts result.
//   overrun    : sticky; a completed result was dropped while valid && !ready.
//   stalled    : no edge seen for TIMEOUT cycles.
// WIDTH must not exceed clock_meter_pkg::MaxWidth.
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             sat,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             stalled
);

  localparam int unsigned        TcntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TcntW-1:0]   TcntLast = TcntW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0]   CntMax   = '1;

  logic unused_sig_sync;
  logic rise, fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sig_in),
    .q    (unused_sig_sync),
    .rise (rise),
    .fall (fall)
  );

  meter_state_t     state_q;
  logic [WIDTH-1:0] high_cnt_q, low_cnt_q;
  logic             sat_acc_q;
  logic [TcntW-1:0] tcnt_q;
  logic [WIDTH-1:0] period_q, high_time_q;
  logic             sat_q, valid_q, overrun_q, stalled_q;

  logic [MaxWidth-1:0] sum_wide;
  logic [WIDTH-1:0]    period_sum;
  logic                publish_sat;
  logic                publish;
  logic                timeout_hit;

  assign sum_wide    = sat_add(MaxWidth'(high_cnt_q), MaxWidth'(low_cnt_q), WIDTH);
  assign period_sum  = sum_wide[WIDTH-1:0];
  assign publish_sat = sat_acc_q |
                       add_overflows(MaxWidth'(high_cnt_q), MaxWidth'(low_cnt_q), WIDTH);
  // A rise in LOW closes one full period.
  assign publish     = enable && (state_q == LOW) && rise;
  assign timeout_hit = (state_q != IDLE) && (tcnt_q == TcntLast) && !rise && !fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      high_cnt_q  <= '0;
      low_cnt_q   <= '0;
      sat_acc_q   <= 1'b0;
      tcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      sat_q       <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      // Result register: a publish may replace the held result only when it is being taken.
      if (publish) begin
        if (!valid_q || ready) begin
          period_q    <= period_sum;
          high_time_q <= high_cnt_q;
          sat_q       <= publish_sat;
          valid_q     <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      if (!enable) begin
        state_q    <= IDLE;
        high_cnt_q <= '0;
        low_cnt_q  <= '0;
        sat_acc_q  <= 1'b0;
        tcnt_q     <= '0;
        stalled_q  <= 1'b0;
      end else begin
        tcnt_q <= (rise || fall) ? '0 : tcnt_q + TcntW'(1);
        unique case (state_q)
          IDLE: begin
            state_q <= ARM;
            tcnt_q  <= '0;
          end
          ARM: begin
            if (rise) begin
              state_q    <= HIGH;
              high_cnt_q <= WIDTH'(1);
              low_cnt_q  <= '0;
              sat_acc_q  <= 1'b0;
            end
          end
          HIGH: begin
            if (fall) begin
              state_q   <= LOW;
              low_cnt_q <= WIDTH'(1);
            end else if (high_cnt_q == CntMax) begin
              sat_acc_q <= 1'b1;
            end else begin
              high_cnt_q <= high_cnt_q + WIDTH'(1);
            end
          end
          LOW: begin
            if (rise) begin
              state_q    <= HIGH;
              high_cnt_q <= WIDTH'(1);
              low_cnt_q  <= '0;
              sat_acc_q  <= 1'b0;
            end else if (low_cnt_q == CntMax) begin
              sat_acc_q <= 1'b1;
            end else begin
              low_cnt_q <= low_cnt_q + WIDTH'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
        if (rise) begin
          stalled_q <= 1'b0;
        end
        // Stalled input: abandon the measurement and wait for a fresh rise.
        if (timeout_hit) begin
          stalled_q  <= 1'b1;
          state_q    <= ARM;
          high_cnt_q <= '0;
          low_cnt_q  <= '0;
          sat_acc_q  <= 1'b0;
          tcnt_q     <= '0;
        end
      end
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign sat       = sat_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign stalled   = stalled_q;

endmodule

// File: tb/tb_clock_meter.sv
// Self-checking bench for clock_meter: two instances (wide with short timeout, and 4-bit),
// expected results queued as waveforms are driven and popped on each valid/ready handshake.
module tb_clock_meter;

  localparam int unsigned WA  = 32;
  localparam int unsigned TOA = 50;
  localparam int unsigned WB  = 4;
  localparam int unsigned TOB = 1000;

  typedef struct {
    int unsigned period;
    int unsigned high;
    bit          sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          sig_a, en_a, rdy_a;
  logic [WA-1:0] period_a, high_a;
  logic          sat_a, valid_a, overrun_a, stalled_a;

  logic          sig_b, en_b, rdy_b;
  logic [WB-1:0] period_b, high_b;
  logic          sat_b, valid_b, overrun_b, stalled_b;

  clock_meter #(.WIDTH(WA), .TIMEOUT(TOA), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_a), .enable(en_a),
    .period(period_a), .high_time(high_a), .sat(sat_a), .valid(valid_a),
    .ready(rdy_a), .overrun(overrun_a), .stalled(stalled_a)
  );

  clock_meter #(.WIDTH(WB), .TIMEOUT(TOB), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_b), .enable(en_b),
    .period(period_b), .high_time(high_b), .sat(sat_b), .valid(valid_b),
    .ready(rdy_b), .overrun(overrun_b), .stalled(stalled_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned w, input int unsigned h,
                                 input int unsigned l);
    longint unsigned mx, hh, ll, s, p;
    exp_t e;
    mx = (64'd1 << w) - 64'd1;
    hh = (64'(h) > mx) ? mx : 64'(h);
    ll = (64'(l) > mx) ? mx : 64'(l);
    s  = hh + ll;
    p  = (s > mx) ? mx : s;
    e.period = 32'(p);
    e.high   = 32'(hh);
    e.sat    = (64'(h) > mx) || (64'(l) > mx) || (s > mx);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid_a && rdy_a) begin
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check_eq("a_period", 64'(period_a), 64'(e.period));
        check_eq("a_high_time", 64'(high_a), 64'(e.high));
        check_eq("a_sat", 64'(sat_a), 64'(e.sat));
      end else begin
        check_eq("a_spurious_valid", 64'(valid_a), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid_b && rdy_b) begin
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check_eq("b_period", 64'(period_b), 64'(e.period));
        check_eq("b_high_time", 64'(high_b), 64'(e.high));
        check_eq("b_sat", 64'(sat_b), 64'(e.sat));
      end else begin
        check_eq("b_spurious_valid", 64'(valid_b), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_sig(input int which, input logic v);
    if (which == 0) sig_a = v;
    else sig_b = v;
  endtask

  task automatic set_en(input int which, input logic v);
    if (which == 0) en_a = v;
    else en_b = v;
  endtask

  function automatic int qsize(input int which);
    return (which == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic push(input int which, input exp_t e);
    if (which == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic wait_drain(input int which, input string tag);
    for (int i = 0; i < 80 && qsize(which) != 0; i++) tick();
    check_eq(tag, 64'(qsize(which)), 64'd0);
  endtask

  // Disable, flush the synchronizer with the input low, then re-enable into ARM.
  task automatic arm(input int which);
    set_sig(which, 1'b0);
    set_en(which, 1'b0);
    ticks(5);
    set_en(which, 1'b1);
    ticks(2);
  endtask

  // n full periods of h high / l low, closed by a final rise so the last one publishes.
  task automatic run_wave(input int which, input int unsigned h, input int unsigned l,
                          input int n, input string tag);
    int unsigned w;
    w = (which == 0) ? WA : WB;
    for (int k = 0; k < n; k++) push(which, model(w, h, l));
    for (int k = 0; k < n; k++) begin
      set_sig(which, 1'b1);
      ticks(int'(h));
      set_sig(which, 1'b0);
      ticks(int'(l));
    end
    set_sig(which, 1'b1);
    wait_drain(which, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    sig_a = 1'b0; en_a = 1'b0; rdy_a = 1'b1;
    sig_b = 1'b0; en_b = 1'b0; rdy_b = 1'b1;
    ticks(3);
    check_eq("rst_period", 64'(period_a), 64'd0);
    check_eq("rst_high_time", 64'(high_a), 64'd0);
    check_eq("rst_sat", 64'(sat_a), 64'd0);
    check_eq("rst_valid", 64'(valid_a), 64'd0);
    check_eq("rst_overrun", 64'(overrun_a), 64'd0);
    check_eq("rst_stalled", 64'(stalled_a), 64'd0);
    check_eq("rst_valid_b", 64'(valid_b), 64'd0);
    reset = 1'b0;
    tick();

    // Continuous 5/6 waveform, consumer always ready.
    arm(0);
    run_wave(0, 5, 6, 4, "t1_drain");
    check_eq("t1_overrun", 64'(overrun_a), 64'd0);

    // Consumer stalls: first result held, later completions dropped.
    arm(0);
    rdy_a = 1'b0;
    set_sig(0, 1'b1); ticks(5);
    set_sig(0, 1'b0); ticks(6);
    set_sig(0, 1'b1); ticks(4);
    check_eq("t2_valid_first", 64'(valid_a), 64'd1);
    check_eq("t2_overrun_first", 64'(overrun_a), 64'd0);
    check_eq("t2_period_first", 64'(period_a), 64'd11);
    check_eq("t2_high_first", 64'(high_a), 64'd5);
    ticks(1);
    set_sig(0, 1'b0); ticks(6);
    set_sig(0, 1'b1); ticks(8);
    check_eq("t2_overrun_set", 64'(overrun_a), 64'd1);
    check_eq("t2_valid_held", 64'(valid_a), 64'd1);
    check_eq("t2_period_held", 64'(period_a), 64'd11);
    check_eq("t2_high_held", 64'(high_a), 64'd5);
    push(0, model(WA, 5, 6));
    rdy_a = 1'b1;
    tick();
    check_eq("t2_valid_drop", 64'(valid_a), 64'd0);
    check_eq("t2_popped", 64'(qsize(0)), 64'd0);
    check_eq("t2_overrun_sticky", 64'(overrun_a), 64'd1);

    // Stuck-high input: rise is consumed 3 clocks after driving, stall 50 clocks later.
    arm(0);
    set_sig(0, 1'b1);
    ticks(52);
    check_eq("t3_not_stalled_yet", 64'(stalled_a), 64'd0);
    tick();
    check_eq("t3_stalled", 64'(stalled_a), 64'd1);
    check_eq("t3_no_valid", 64'(valid_a), 64'd0);
    set_sig(0, 1'b0);
    ticks(4);
    check_eq("t3_fall_keeps_stall", 64'(stalled_a), 64'd1);
    run_wave(0, 4, 5, 1, "t3_drain");
    check_eq("t3_stall_cleared", 64'(stalled_a), 64'd0);

    // Enable dropped mid-HIGH: the partial period must not publish.
    arm(0);
    set_sig(0, 1'b1);
    ticks(6);
    set_en(0, 1'b0);
    ticks(2);
    check_eq("t4_no_partial", 64'(valid_a), 64'd0);
    set_sig(0, 1'b0);
    ticks(5);
    set_en(0, 1'b1);
    ticks(2);
    run_wave(0, 3, 4, 2, "t4_drain");

    // Reset while a result is pending and the FSM is in LOW.
    arm(0);
    rdy_a = 1'b0;
    set_sig(0, 1'b1); ticks(5);
    set_sig(0, 1'b0); ticks(6);
    set_sig(0, 1'b1); ticks(5);
    set_sig(0, 1'b0); ticks(4);
    check_eq("t5_pre_valid", 64'(valid_a), 64'd1);
    reset = 1'b1;
    tick();
    check_eq("t5_period", 64'(period_a), 64'd0);
    check_eq("t5_high_time", 64'(high_a), 64'd0);
    check_eq("t5_sat", 64'(sat_a), 64'd0);
    check_eq("t5_valid", 64'(valid_a), 64'd0);
    check_eq("t5_overrun", 64'(overrun_a), 64'd0);
    check_eq("t5_stalled", 64'(stalled_a), 64'd0);
    reset = 1'b0;
    rdy_a = 1'b1;
    set_en(0, 1'b0);
    tick();
    check_eq("t5_valid_after", 64'(valid_a), 64'd0);

    // 4-bit instance: plain, high-phase saturation, sum-only saturation.
    arm(1);
    run_wave(1, 3, 4, 1, "b1_drain");
    arm(1);
    run_wave(1, 20, 3, 2, "b2_drain");
    arm(1);
    run_wave(1, 2, 14, 1, "b3_drain");
    check_eq("b_overrun", 64'(overrun_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
